// File: rtl/multadd_pkg.sv
// Shared definitions for the multiply-add divider: FSM state encoding,
// default datapath widths and the step-counter width helper.
package multadd_pkg;

  // Defaults match the multiply-add unit: 17-bit result bus, 8-bit operands.
  localparam int DEF_DIVIDEND_W = 17;
  localparam int DEF_DIVISOR_W  = 8;

  // Step counter must be able to hold DIVIDEND_W itself.
  function automatic int stepCntWidth(input int dividendW);
    return $clog2(dividendW + 1);
  endfunction

  localparam int DEF_STEP_CNT_W = stepCntWidth(DEF_DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divState_t;

endpackage : multadd_pkg

// File: rtl/multadd_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep or restore.
module multadd_div_step
  import multadd_pkg::*;
#(
  parameter int DIVISOR_W = DEF_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   partRem,
  input  logic                 dividendBit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   newRem,
  output logic                 quotBit
);

  logic [DIVISOR_W:0] shifted;
  logic [DIVISOR_W:0] trial;

  // Shift, trial-subtract and select the restored or reduced remainder.
  always_comb begin
    // NOTE: every variable is assigned on every path through this block, so
    // no latch can be inferred.
    shifted = {partRem[DIVISOR_W-1:0], dividendBit};
    trial   = shifted - {1'b0, divisor};
    // A set top bit means the shifted value overflowed DIVISOR_W+1 bits and
    // certainly exceeds the divisor; otherwise the borrow bit is the sign.
    quotBit = partRem[DIVISOR_W] | ~trial[DIVISOR_W];
    newRem  = quotBit ? trial : shifted;
  end

endmodule : multadd_div_step

// File: rtl/multadd_divider.sv
// Sequential restoring divider downstream of the multiply-add unit.
// Produces one quotient bit per clock with a start/busy/done handshake.
// Optional self-check of quotient*divisor+remainder is enabled by defining
// MULTADD_DIV_CHECK_EN; without it oCHK_ERR is tied low.
module multadd_divider
  import multadd_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iSTART,
  input  logic [DIVIDEND_W-1:0] iDIVIDEND,
  input  logic [DIVISOR_W-1:0]  iDIVISOR,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic [DIVIDEND_W-1:0] oQUOTIENT,
  output logic [DIVISOR_W-1:0]  oREMAINDER,
  output logic                  oDIV0,
  output logic                  oCHK_ERR
);

  localparam int CNT_W = stepCntWidth(DIVIDEND_W);

  divState_t             state;
  logic [DIVIDEND_W-1:0] shiftReg;    // dividend bits shift out, quotient bits shift in
  logic [DIVISOR_W-1:0]  divisorReg;
  logic [DIVISOR_W:0]    partRem;
  logic [CNT_W-1:0]      stepCnt;

  logic [DIVISOR_W:0]    nextRem;
  logic                  quotBit;
  logic [DIVIDEND_W-1:0] nextQuot;
  logic                  startAccept;
  logic                  lastStep;

  multadd_div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) uStep (
    .partRem     (partRem),
    .dividendBit (shiftReg[DIVIDEND_W-1]),
    .divisor     (divisorReg),
    .newRem      (nextRem),
    .quotBit     (quotBit)
  );

  assign nextQuot    = {shiftReg[DIVIDEND_W-2:0], quotBit};
  assign startAccept = iSTART && (state != RUN);
  assign lastStep    = (state == RUN) && (stepCnt == CNT_W'(1));

  // Control FSM and datapath registers; results are registered outputs.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state      <= IDLE;
      shiftReg   <= '0;
      divisorReg <= '0;
      partRem    <= '0;
      stepCnt    <= '0;
      oBUSY      <= 1'b0;
      oDONE      <= 1'b0;
      oQUOTIENT  <= '0;
      oREMAINDER <= '0;
      oDIV0      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values of the others, independent of statement order.
      oDONE <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (startAccept) begin
            shiftReg   <= iDIVIDEND;
            divisorReg <= iDIVISOR;
            partRem    <= '0;
            stepCnt    <= CNT_W'(DIVIDEND_W);
            if (iDIVISOR == '0) begin
              // Divide-by-zero completes at once without a RUN phase.
              state      <= DONE;
              oDONE      <= 1'b1;
              oQUOTIENT  <= '1;
              oREMAINDER <= '0;
              oDIV0      <= 1'b1;
            end else begin
              state <= RUN;
              oBUSY <= 1'b1;
            end
          end
        end
        RUN: begin
          shiftReg <= nextQuot;
          partRem  <= nextRem;
          stepCnt  <= stepCnt - CNT_W'(1);
          if (lastStep) begin
            state      <= DONE;
            oBUSY      <= 1'b0;
            oDONE      <= 1'b1;
            oQUOTIENT  <= nextQuot;
            // Remainder is always below the divisor, so the top bit is zero.
            oREMAINDER <= nextRem[DIVISOR_W-1:0];
            oDIV0      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULTADD_DIV_CHECK_EN
  logic [DIVIDEND_W-1:0]           capturedDividend;
  logic [DIVIDEND_W+DIVISOR_W-1:0] rebuilt;
  logic                            chkMismatch;

  // Rebuild the dividend from the final quotient and remainder.
  always_comb begin
    rebuilt = {{DIVISOR_W{1'b0}}, nextQuot} * {{DIVIDEND_W{1'b0}}, divisorReg}
            + {{DIVIDEND_W{1'b0}}, nextRem[DIVISOR_W-1:0]};
    chkMismatch = (rebuilt != {{DIVISOR_W{1'b0}}, capturedDividend});
  end

  // Capture the dividend on acceptance and flag a mismatch with oDONE.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      capturedDividend <= '0;
      oCHK_ERR         <= 1'b0;
    end else if (startAccept) begin
      capturedDividend <= iDIVIDEND;
      oCHK_ERR         <= 1'b0;
    end else if (lastStep) begin
      oCHK_ERR <= chkMismatch;
    end
  end
`else
  assign oCHK_ERR = 1'b0;
`endif

endmodule : multadd_divider

// File: tb/tb_multadd_divider.sv
// Self-checking bench for multadd_divider: a cycle-level timeline model
// (integer divide/modulo plus a countdown) compared on every negedge,
// directed scenarios with hand-computed results, and a random phase.
module tb_multadd_divider;

  localparam int DW = 17;
  localparam int SW = 8;

  logic          iCLK;
  logic          iRST;
  logic          iSTART;
  logic [DW-1:0] iDIVIDEND;
  logic [SW-1:0] iDIVISOR;
  logic          oBUSY;
  logic          oDONE;
  logic [DW-1:0] oQUOTIENT;
  logic [SW-1:0] oREMAINDER;
  logic          oDIV0;
  logic          oCHK_ERR;

  int checks   = 0;
  int failures = 0;

  multadd_divider #(
    .DIVIDEND_W (DW),
    .DIVISOR_W  (SW)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iSTART     (iSTART),
    .iDIVIDEND  (iDIVIDEND),
    .iDIVISOR   (iDIVISOR),
    .oBUSY      (oBUSY),
    .oDONE      (oDONE),
    .oQUOTIENT  (oQUOTIENT),
    .oREMAINDER (oREMAINDER),
    .oDIV0      (oDIV0),
    .oCHK_ERR   (oCHK_ERR)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An accepted non-zero division completes DW edges later with a/b, a%b;
  // a zero divisor completes on the accepting edge. Starts while busy are
  // dropped.
  logic          mBusy  = 1'b0;
  logic          mDone  = 1'b0;
  logic [DW-1:0] mQ     = '0;
  logic [SW-1:0] mR     = '0;
  logic          mDiv0  = 1'b0;
  int            mLeft  = 0;
  logic [DW-1:0] pendQ  = '0;
  logic [SW-1:0] pendR  = '0;
  int            nDone  = 0;

  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      mBusy <= 1'b0;
      mDone <= 1'b0;
      mQ    <= '0;
      mR    <= '0;
      mDiv0 <= 1'b0;
      mLeft <= 0;
    end else begin
      mDone <= 1'b0;
      if (mBusy) begin
        if (mLeft == 1) begin
          mBusy <= 1'b0;
          mDone <= 1'b1;
          mQ    <= pendQ;
          mR    <= pendR;
          mDiv0 <= 1'b0;
          nDone <= nDone + 1;
        end
        mLeft <= mLeft - 1;
      end else if (iSTART) begin
        if (iDIVISOR == '0) begin
          mDone <= 1'b1;
          mQ    <= '1;
          mR    <= '0;
          mDiv0 <= 1'b1;
          nDone <= nDone + 1;
        end else begin
          mBusy <= 1'b1;
          mLeft <= DW;
          pendQ <= iDIVIDEND / DW'(iDIVISOR);
          pendR <= SW'(iDIVIDEND % DW'(iDIVISOR));
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge iCLK) begin
    check("busy",      {31'd0, oBUSY},      {31'd0, mBusy});
    check("done",      {31'd0, oDONE},      {31'd0, mDone});
    check("quotient",  {15'd0, oQUOTIENT},  {15'd0, mQ});
    check("remainder", {24'd0, oREMAINDER}, {24'd0, mR});
    check("div0",      {31'd0, oDIV0},      {31'd0, mDiv0});
    check("chk_err",   {31'd0, oCHK_ERR},   32'd0);
  end

  // ---------------- stimulus helpers ----------------
  // Called 1 time unit after a rising edge; returns 1 unit after the
  // accepting edge.
  task automatic startOp(input logic [DW-1:0] a, input logic [SW-1:0] b);
    iDIVIDEND = a;
    iDIVISOR  = b;
    iSTART    = 1'b1;
    @(posedge iCLK);
    #1;
    iSTART = 1'b0;
  endtask

  // Counts rising edges until oDONE is seen; bounded at 40 edges.
  task automatic waitDone(output int edges);
    edges = 0;
    while (!oDONE && edges < 40) begin
      @(posedge iCLK);
      #1;
      edges++;
    end
    if (!oDONE) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic expectResult(input string tag, input logic [DW-1:0] q,
                              input logic [SW-1:0] r, input logic z);
    check({tag, "_q"},    {15'd0, oQUOTIENT},  {15'd0, q});
    check({tag, "_r"},    {24'd0, oREMAINDER}, {24'd0, r});
    check({tag, "_div0"}, {31'd0, oDIV0},      {31'd0, z});
    check({tag, "_mq"},   {15'd0, mQ},         {15'd0, q});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    int cyc;

    iRST = 1'b0;
    iSTART = 1'b0;
    iDIVIDEND = '0;
    iDIVISOR = '0;
    #2 iRST = 1'b1;
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_busy", {31'd0, oBUSY}, 32'd0);
    check("rst_done", {31'd0, oDONE}, 32'd0);
    check("rst_q",    {15'd0, oQUOTIENT}, 32'd0);
    check("rst_r",    {24'd0, oREMAINDER}, 32'd0);
    check("rst_div0", {31'd0, oDIV0}, 32'd0);
    iRST = 1'b0;
    @(posedge iCLK);
    #1;

    // 13 / 3
    startOp(17'd13, 8'd3);
    check("run_busy", {31'd0, oBUSY}, 32'd1);
    waitDone(lat);
    check("lat_13_3", lat, 32'd17);
    check("done_busy", {31'd0, oBUSY}, 32'd0);
    expectResult("d13_3", 17'd4, 8'd1, 1'b0);
    @(posedge iCLK);
    #1;

    // 29 / 2, then back-to-back max / 255
    startOp(17'd29, 8'd2);
    waitDone(lat);
    expectResult("d29_2", 17'd14, 8'd1, 1'b0);
    startOp(17'h1FFFF, 8'hFF);
    waitDone(lat);
    check("lat_b2b", lat, 32'd17);
    expectResult("dmax", 17'd514, 8'd1, 1'b0);
    @(posedge iCLK);
    #1;

    // divide by zero
    startOp(17'd100, 8'd0);
    waitDone(lat);
    check("lat_div0", lat, 32'd0);
    check("div0_busy", {31'd0, oBUSY}, 32'd0);
    expectResult("d100_0", 17'h1FFFF, 8'd0, 1'b1);
    @(posedge iCLK);
    #1;
    check("div0_single_pulse", {31'd0, oDONE}, 32'd0);

    // start during RUN is ignored; restart in the DONE cycle is accepted
    startOp(17'd50, 8'd7);
    repeat (4) begin
      @(posedge iCLK);
      #1;
    end
    iDIVIDEND = 17'd9;
    iDIVISOR  = 8'd3;
    iSTART    = 1'b1;
    @(posedge iCLK);
    #1;
    iSTART = 1'b0;
    waitDone(lat);
    check("lat_ignored", lat, 32'd12);
    expectResult("d50_7", 17'd7, 8'd1, 1'b0);
    startOp(17'd9, 8'd3);
    waitDone(lat);
    check("lat_restart", lat, 32'd17);
    expectResult("d9_3", 17'd3, 8'd0, 1'b0);
    @(posedge iCLK);
    #1;

    // reset in mid-operation
    startOp(17'd200, 8'd9);
    repeat (7) begin
      @(posedge iCLK);
      #1;
    end
    iRST = 1'b1;
    #1;
    check("abort_busy", {31'd0, oBUSY}, 32'd0);
    check("abort_q",    {15'd0, oQUOTIENT}, 32'd0);
    check("abort_r",    {24'd0, oREMAINDER}, 32'd0);
    repeat (3) @(posedge iCLK);
    #1;
    check("abort_done", {31'd0, oDONE}, 32'd0);
    iRST = 1'b0;
    @(posedge iCLK);
    #1;
    startOp(17'd200, 8'd9);
    waitDone(lat);
    expectResult("d200_9", 17'd22, 8'd2, 1'b0);
    @(posedge iCLK);
    #1;

    // random phase: free-running random starts, model tracks acceptance
    base = nDone;
    cyc  = 0;
    while (nDone < base + 1000 && cyc < 40000) begin
      iSTART    = ($urandom_range(3) == 0);
      iDIVIDEND = DW'($urandom);
      iDIVISOR  = ($urandom_range(15) == 0) ? 8'd0 : SW'($urandom_range(255, 1));
      @(posedge iCLK);
      #1;
      cyc++;
    end
    iSTART = 1'b0;
    check("random_ops_completed", {31'd0, (nDone - base) >= 1000}, 32'd1);
    repeat (20) @(posedge iCLK);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_multadd_divider
